// File: rtl/dm_access_ctrl_if.sv
// Pipeline-to-DM bus for dm_access_ctrl: M-stage request/response plus the data-memory port.
// master = pipeline/DM environment, slave = the access controller.
interface dm_access_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_pc;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        dm_ce;
  logic        dm_we;
  logic        dm_re;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_pc;
  logic [31:0] dm_dout;
  logic        dm_ready;

  modport master (
    output req_valid, req_op, req_pc, req_addr, req_wdata, dm_dout, dm_ready,
    input  req_ready, stall, rsp_valid, rsp_rdata, exc_valid, exc_code,
           dm_ce, dm_we, dm_re, dm_be, dm_addr, dm_din, dm_pc
  );

  modport slave (
    input  req_valid, req_op, req_pc, req_addr, req_wdata, dm_dout, dm_ready,
    output req_ready, stall, rsp_valid, rsp_rdata, exc_valid, exc_code,
           dm_ce, dm_we, dm_re, dm_be, dm_addr, dm_din, dm_pc
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// Memory-stage load/store controller in front of the data memory (alignment, lanes, extension).
// Optional posted-store buffer: `define DM_POSTED_STORE_EN.
module dm_access_ctrl #(
  parameter logic [4:0] EXC_ADEL = 5'd4,
  parameter logic [4:0] EXC_ADES = 5'd5
) (
  input  logic            clk,
  input  logic            reset,
  dm_access_ctrl_if.slave bus
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t state_q, state_nxt;

  logic        req_ready;
  logic        req_store;
  logic        req_mis;
  logic        start;
  logic        trap;
  logic        finish;

  logic        dm_ce_p1;
  logic        dm_we_p1;
  logic        dm_re_p1;
  logic [3:0]  dm_be_p1;
  logic [31:0] dm_addr_p1;
  logic [31:0] dm_din_p1;
  logic [31:0] dm_pc_p1;
  logic        rsp_vld_p1;
  logic [31:0] rsp_rdata_p1;
  logic        exc_vld_p1;
  logic [4:0]  exc_code_p1;
  logic [2:0]  op_p1;
  logic [1:0]  lane_p1;
`ifdef DM_POSTED_STORE_EN
  logic        posted_p1;
`endif

  function automatic logic is_store(input logic [2:0] op);
    return op[2] & (op[1] | op[0]);
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         return a != 2'b00;
      OP_LH, OP_LHU, OP_SH: return a[0];
      default:              return 1'b0;
    endcase
  endfunction

  // Loads read the whole word; extraction happens on the way back.
  function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_SH:   return a[1] ? 4'b1100 : 4'b0011;
      OP_SB:   return 4'b0001 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] op, input logic [31:0] w);
    case (op)
      OP_SW:   return w;
      OP_SH:   return {2{w[15:0]}};
      OP_SB:   return {4{w[7:0]}};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] a,
                                              input logic [31:0] dout);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (a)
      2'd0:    b = dout[7:0];
      2'd1:    b = dout[15:8];
      2'd2:    b = dout[23:16];
      default: b = dout[31:24];
    endcase
    h = a[1] ? dout[31:16] : dout[15:0];
    case (op)
      OP_LW:   return dout;
      OP_LH:   return 32'(h);
      OP_LHU:  return {16'd0, h};
      OP_LB:   return 32'(b);
      OP_LBU:  return {24'd0, b};
      default: return 32'd0;
    endcase
  endfunction

  assign req_ready     = (state_q == IDLE);
  assign req_store     = is_store(bus.req_op);
  assign req_mis       = misaligned(bus.req_op, bus.req_addr[1:0]);
  assign bus.req_ready = req_ready;
  assign bus.stall     = bus.req_valid & ~req_ready;

  always_comb begin
    state_nxt = state_q;
    start     = 1'b0;
    trap      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_mis) begin
            trap = 1'b1;
          end else begin
            start     = 1'b1;
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bus.dm_ready) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: request accepted, DM port registered; response/exception pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      dm_ce_p1     <= 1'b0;
      dm_we_p1     <= 1'b0;
      dm_re_p1     <= 1'b0;
      dm_be_p1     <= '0;
      dm_addr_p1   <= '0;
      dm_din_p1    <= '0;
      dm_pc_p1     <= '0;
      rsp_vld_p1   <= 1'b0;
      rsp_rdata_p1 <= '0;
      exc_vld_p1   <= 1'b0;
      exc_code_p1  <= '0;
`ifdef DM_POSTED_STORE_EN
      posted_p1    <= 1'b0;
`endif
    end else begin
      state_q      <= state_nxt;
      rsp_vld_p1   <= 1'b0;
      rsp_rdata_p1 <= '0;
      exc_vld_p1   <= 1'b0;
      exc_code_p1  <= '0;
      if (trap) begin
        exc_vld_p1  <= 1'b1;
        exc_code_p1 <= req_store ? EXC_ADES : EXC_ADEL;
      end
      if (start) begin
        dm_ce_p1   <= 1'b1;
        dm_we_p1   <= req_store;
        dm_re_p1   <= ~req_store;
        dm_be_p1   <= byte_en(bus.req_op, bus.req_addr[1:0]);
        dm_addr_p1 <= {bus.req_addr[31:2], 2'b00};
        dm_din_p1  <= lane_data(bus.req_op, bus.req_wdata);
        dm_pc_p1   <= bus.req_pc;
`ifdef DM_POSTED_STORE_EN
        // Stores are acknowledged immediately and drain in the background.
        posted_p1  <= req_store;
        rsp_vld_p1 <= req_store;
`endif
      end
      if (finish) begin
        dm_ce_p1 <= 1'b0;
        dm_we_p1 <= 1'b0;
        dm_re_p1 <= 1'b0;
`ifdef DM_POSTED_STORE_EN
        posted_p1 <= 1'b0;
        if (!posted_p1) begin
          rsp_vld_p1   <= 1'b1;
          rsp_rdata_p1 <= load_extend(op_p1, lane_p1, bus.dm_dout);
        end
`else
        rsp_vld_p1   <= 1'b1;
        rsp_rdata_p1 <= load_extend(op_p1, lane_p1, bus.dm_dout);
`endif
      end
    end
  end

  // Request fields needed only at completion; only read in ACCESS, so no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      op_p1   <= bus.req_op;
      lane_p1 <= bus.req_addr[1:0];
    end
  end

  assign bus.dm_ce     = dm_ce_p1;
  assign bus.dm_we     = dm_we_p1;
  assign bus.dm_re     = dm_re_p1;
  assign bus.dm_be     = dm_be_p1;
  assign bus.dm_addr   = dm_addr_p1;
  assign bus.dm_din    = dm_din_p1;
  assign bus.dm_pc     = dm_pc_p1;
  assign bus.rsp_valid = rsp_vld_p1;
  assign bus.rsp_rdata = rsp_rdata_p1;
  assign bus.exc_valid = exc_vld_p1;
  assign bus.exc_code  = exc_code_p1;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Randomized self-checking bench for dm_access_ctrl against a behavioural load/store model.
module tb_dm_access_ctrl;
  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [31:0] mem [64];

  dm_access_ctrl_if bus ();

  dm_access_ctrl #(.EXC_ADEL(5'd4), .EXC_ADES(5'd5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  // Reference rules: access size, lanes and extension computed arithmetically.
  function automatic int unsigned ref_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd5) return 4;
    if (op == 3'd1 || op == 3'd2 || op == 3'd6) return 2;
    return 1;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] op, input logic [31:0] addr);
    if (ref_size(op) == 4) return 4'hF;
    if (ref_size(op) == 2) return 4'(32'd3 << (addr % 4));
    return 4'(32'd1 << (addr % 4));
  endfunction

  function automatic logic [31:0] ref_din(input logic [2:0] op, input logic [31:0] w);
    if (ref_size(op) == 4) return w;
    if (ref_size(op) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return (w & 32'hFF) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * (addr % 4));
    case (op)
      3'd0: return word;
      3'd1: return (v & 32'hFFFF) | ((v & 32'h8000) != 0 ? 32'hFFFF_0000 : 32'd0);
      3'd2: return v & 32'hFFFF;
      3'd3: return (v & 32'hFF) | ((v & 32'h80) != 0 ? 32'hFFFF_FF00 : 32'd0);
      3'd4: return v & 32'hFF;
      default: return 32'd0;
    endcase
  endfunction

  // One transaction, entered at posedge+1 with the controller idle; returns at posedge+1
  // of the completion (or exception) cycle, so consecutive calls run back-to-back.
  task automatic run_txn(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input bit hold);
    logic [31:0] pc, rd_e, din_e;
    logic [3:0]  be_e;
    logic [5:0]  idx;
    bit st, mis, posted;
    pc     = $urandom;
    st     = (op >= 3'd5);
    mis    = (addr % ref_size(op)) != 0;
    be_e   = ref_be(op, addr);
    din_e  = ref_din(op, wdata);
    idx    = addr[7:2];
    posted = 1'b0;
`ifdef DM_POSTED_STORE_EN
    posted = st;
`endif
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_pc    = pc;
    bus.dm_ready  = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL accept: req_ready=%b stall=%b required 1 0", bus.req_ready, bus.stall);
    end
    @(posedge clk); #1;
    bus.req_valid = hold & ~mis;
    if (hold) begin
      bus.req_op    = 3'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
    end
    if (mis) begin
      checks++;
      if (bus.exc_valid !== 1'b1 || bus.exc_code !== (st ? 5'd5 : 5'd4) ||
          bus.dm_ce !== 1'b0 || bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL misaligned op=%0d addr=%h: exc=%b code=%0d ce=%b rsp=%b required 1 %0d 0 0",
                 op, addr, bus.exc_valid, bus.exc_code, bus.dm_ce, bus.rsp_valid, st ? 5 : 4);
      end
      return;
    end
    checks++;
    if (bus.dm_ce !== 1'b1 || bus.dm_we !== st || bus.dm_re !== !st ||
        bus.dm_addr !== {addr[31:2], 2'b00} || bus.dm_pc !== pc ||
        bus.exc_valid !== 1'b0 || bus.exc_code !== 5'd0) begin
      errors++;
      $display("FAIL dm_issue op=%0d: ce=%b we=%b re=%b addr=%h pc=%h exc=%b required 1 %b %b %h %h 0",
               op, bus.dm_ce, bus.dm_we, bus.dm_re, bus.dm_addr, bus.dm_pc, bus.exc_valid,
               st, !st, {addr[31:2], 2'b00}, pc);
    end
    if (st) begin
      checks++;
      if (bus.dm_be !== be_e || bus.dm_din !== din_e) begin
        errors++;
        $display("FAIL store_lanes op=%0d addr=%h: be=%b din=%h required be=%b din=%h",
                 op, addr, bus.dm_be, bus.dm_din, be_e, din_e);
      end
    end
    checks++;
    if (bus.rsp_valid !== posted || (posted && bus.rsp_rdata !== 32'd0)) begin
      errors++;
      $display("FAIL first_access_rsp: rsp_valid=%b rdata=%h required %b", bus.rsp_valid,
               bus.rsp_rdata, posted);
    end
    for (int w = 0; w <= waits; w++) begin
      if (w > 0) begin
        checks++;
        if (bus.dm_ce !== 1'b1 || bus.dm_addr !== {addr[31:2], 2'b00} || bus.dm_pc !== pc ||
            (st && (bus.dm_be !== be_e || bus.dm_din !== din_e)) ||
            bus.rsp_valid !== 1'b0 || (hold && bus.stall !== 1'b1)) begin
          errors++;
          $display("FAIL wait_hold w=%0d: ce=%b addr=%h be=%b din=%h rsp=%b stall=%b required stable, no rsp",
                   w, bus.dm_ce, bus.dm_addr, bus.dm_be, bus.dm_din, bus.rsp_valid, bus.stall);
        end
      end
      bus.dm_ready = (w == waits);
      if (w == waits) bus.dm_dout = mem[idx];
      @(posedge clk); #1;
    end
    bus.dm_ready  = 1'b0;
    bus.req_valid = 1'b0;
    bus.dm_dout   = $urandom;
    rd_e = ref_load(op, addr, mem[idx]);
    if (st) begin
      for (int i = 0; i < 4; i++)
        if (be_e[i]) mem[idx][8*i +: 8] = din_e[8*i +: 8];
    end
    checks++;
    if (bus.rsp_valid !== !posted || (!posted && bus.rsp_rdata !== rd_e) || bus.dm_ce !== 1'b0 ||
        bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL complete op=%0d addr=%h: rsp=%b rdata=%h ce=%b ready=%b required rsp=%b rdata=%h ce=0 ready=1",
               op, addr, bus.rsp_valid, bus.rsp_rdata, bus.dm_ce, bus.req_ready, !posted, rd_e);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.dm_ce, bus.dm_we, bus.dm_re, bus.dm_be, bus.dm_addr, bus.dm_din, bus.dm_pc,
         bus.rsp_valid, bus.rsp_rdata, bus.exc_valid, bus.exc_code} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ce=%b rsp=%b exc=%b addr=%h required all zero",
               bus.dm_ce, bus.rsp_valid, bus.exc_valid, bus.dm_addr);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b required 1", bus.req_ready);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_word;
    mem[4] = 32'h8899_AABB;
    run_txn(3'd0, 32'h10, 32'd0, 0, 1'b0);
  endtask

  task automatic test_byte_loads;
    run_txn(3'd3, 32'h13, 32'd0, 0, 1'b0);
    run_txn(3'd4, 32'h13, 32'd0, 0, 1'b0);
    run_txn(3'd1, 32'h12, 32'd0, 1, 1'b0);
    run_txn(3'd2, 32'h12, 32'd0, 0, 1'b0);
  endtask

  task automatic test_store_lanes;
    run_txn(3'd6, 32'h22, 32'h0000_1234, 0, 1'b0);
    run_txn(3'd7, 32'h21, 32'hCAFE_F00D, 0, 1'b0);
    run_txn(3'd5, 32'h24, 32'hDEAD_BEEF, 1, 1'b0);
    run_txn(3'd0, 32'h20, 32'd0, 0, 1'b0);
  endtask

  task automatic test_misaligned;
    run_txn(3'd0, 32'h06, 32'd0, 0, 1'b0);
    run_txn(3'd6, 32'h23, 32'h55, 0, 1'b0);
    run_txn(3'd7, 32'h07, 32'hA5, 0, 1'b0);
    run_txn(3'd7, 32'h0B, 32'h3C, 0, 1'b0);
  endtask

  task automatic test_wait_states;
    run_txn(3'd0, 32'h10, 32'd0, 3, 1'b1);
    run_txn(3'd5, 32'h30, 32'h1357_9BDF, 3, 1'b0);
  endtask

  task automatic test_idle_ready;
    bus.req_valid = 1'b0;
    bus.dm_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.dm_ce !== 1'b0 || bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_dm_ready: rsp=%b ce=%b ready=%b required 0 0 1",
                 bus.rsp_valid, bus.dm_ce, bus.req_ready);
      end
    end
    bus.dm_ready = 1'b0;
  endtask

  task automatic test_reset_in_access;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'h10;
    bus.req_pc    = 32'h0000_4000;
    bus.dm_ready  = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (bus.dm_ce !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_access: dm_ce=%b required 1", bus.dm_ce);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.dm_ce, bus.dm_re, bus.dm_addr, bus.dm_pc, bus.rsp_valid} !== '0) begin
      errors++;
      $display("FAIL async_reset: ce=%b re=%b addr=%h pc=%h rsp=%b required all zero",
               bus.dm_ce, bus.dm_re, bus.dm_addr, bus.dm_pc, bus.rsp_valid);
    end
    bus.dm_ready = 1'b1;
    bus.dm_dout  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.dm_ce !== 1'b0) begin
        errors++;
        $display("FAIL reset_drop: rsp=%b ce=%b required 0 0", bus.rsp_valid, bus.dm_ce);
      end
    end
    bus.dm_ready = 1'b0;
  endtask

`ifdef DM_POSTED_STORE_EN
  task automatic test_posted;
    logic [31:0] w;
    w = $urandom;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd5;
    bus.req_addr  = 32'h40;
    bus.req_wdata = w;
    bus.req_pc    = 32'h0000_8000;
    bus.dm_ready  = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'd0 || bus.dm_we !== 1'b1) begin
      errors++;
      $display("FAIL posted_ack: rsp=%b rdata=%h we=%b required 1 0 1",
               bus.rsp_valid, bus.rsp_rdata, bus.dm_we);
    end
    bus.req_op = 3'd0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.stall !== 1'b1 || bus.req_ready !== 1'b0 || (i > 0 && bus.rsp_valid !== 1'b0)) begin
        errors++;
        $display("FAIL posted_drain_stall i=%0d: stall=%b ready=%b rsp=%b required 1 0",
                 i, bus.stall, bus.req_ready, bus.rsp_valid);
      end
      bus.dm_ready = (i == 2);
      @(posedge clk); #1;
    end
    mem[16] = w;
    bus.dm_ready = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.stall !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL posted_release: ready=%b stall=%b rsp=%b required 1 0 0",
               bus.req_ready, bus.stall, bus.rsp_valid);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.dm_ready  = 1'b1;
    bus.dm_dout   = mem[16];
    @(posedge clk); #1;
    bus.dm_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== w) begin
      errors++;
      $display("FAIL posted_readback: rsp=%b rdata=%h required 1 %h", bus.rsp_valid, bus.rsp_rdata, w);
    end
  endtask
`endif

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      run_txn(3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom,
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_pc    = 32'd0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.dm_ready  = 1'b0;
    bus.dm_dout   = 32'd0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    test_reset();
    test_load_word();
    test_byte_loads();
    test_store_lanes();
    test_misaligned();
    test_wait_states();
    test_idle_ready();
    test_reset_in_access();
`ifdef DM_POSTED_STORE_EN
    test_posted();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
